etc_block_scheduler: RTL and testbench
======================================

Name: etc_block_scheduler

Overview:
- Sequences the ETC RGB decoder datapath for one compressed 4x4 block at a time.
- Accepts a block descriptor over a valid/ready handshake and registers it.
- Issues 16 single-pixel decode requests (pixIdx 0..15) to the decoder and captures each RGBA result.
- Streams pixels downstream with image coordinates under backpressure; sits between the block fetch logic and the framebuffer writer.

Parameters:
- COORD_W, 12, width of block-grid coordinates blk_x/blk_y; pixel coordinates are COORD_W+2 bits.
- TIMEOUT, 64, maximum cycles to wait for decoder color_rts per pixel before declaring a timeout.

Ports:
- sclk  in  1  clock.
- rsrt  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  block descriptor valid.
- in_ready  out  1  scheduler can accept a descriptor.
- in_block  in  64  compressed ETC block.
- in_mode  in  3  decoded mode (Individual/Differential/T/H/Planar encoding of etc_param.vh).
- in_punch  in  1  punch-through flag.
- in_alpha  in  1  alpha flag.
- in_blk_x  in  COORD_W  block column.
- in_blk_y  in  COORD_W  block row.
- dec_rtr  out  1  one-cycle decode request pulse to decoder.
- dec_mode  out  3  registered mode to decoder.
- dec_block  out  64  registered block to decoder.
- dec_punch  out  1  registered punch-through flag.
- dec_alpha  out  1  registered alpha flag.
- dec_pixIdx  out  4  pixel index being decoded.
- dec_color_rts  in  1  decoder result strobe.
- dec_r, dec_g, dec_b, dec_a  in  8 each  decoder colour outputs.
- px_valid  out  1  output pixel valid.
- px_ready  in  1  downstream accepts pixel.
- px_x, px_y  out  COORD_W+2 each  pixel image coordinates.
- px_rgba  out  32  {r,g,b,a}.
- px_last  out  1  marks pixel 15 of the block.
- timeout_err  out  1  sticky; set on any decode timeout.

Behaviour:
- Reset (rsrt=0, async): state IDLE; all outputs 0 except in_ready=1; registers, counters and timeout_err cleared.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch all in_* fields, set idx=0, go ISSUE.
  - in_ready is 0 in every other state.
- ISSUE:
  - dec_rtr=1 for exactly one cycle with dec_pixIdx=idx.
  - Clear wait counter; go WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - On dec_color_rts: capture {dec_r,dec_g,dec_b,dec_a} into px_rgba; go OUT.
  - If the counter reaches TIMEOUT without color_rts: px_rgba=0, set timeout_err, go OUT (the pixel is still emitted).
  - color_rts and timeout in the same cycle: color_rts wins and no error is set.
- OUT:
  - px_valid=1; px_rgba, px_x, px_y, px_last held stable until px_valid&&px_ready.
  - ETC ordering is column-major: px_x = {blk_x,2'b00} + idx[3:2]; px_y = {blk_y,2'b00} + idx[1:0].
  - px_last = (idx==15).
  - On handshake: if idx==15 go IDLE, else idx+1 and go ISSUE.
- Throughput: each pixel takes at least 3 cycles plus decoder latency. Minimum block time is 48 cycles plus 16x decoder latency.
- Held fields: dec_mode, dec_block, dec_punch, dec_alpha stay at the latched values from IDLE exit until the next acceptance. dec_pixIdx holds idx in all states.
- dec_color_rts outside WAIT is ignored.
- idx is 4 bits. The wrap after 15 never occurs because the 15→IDLE transition takes precedence.
- timeout_err clears only on reset.
- A reset mid-block aborts immediately: the partial block is discarded, px_valid drops to 0, and no further dec_rtr is issued.

Test Plan:
- Single block, mode Individual, decoder model latency 2, px_ready=1.
  - Exactly 16 dec_rtr pulses with pixIdx 0..15.
  - 16 pixels emitted; px_last only on the 16th.
  - blk_x=3, blk_y=5: pixel idx 6 at px_x=13, px_y=22.
  - in_ready returns to 1 after the final handshake.
- Backpressure: px_ready low for 10 cycles on pixel 4.
  - px_valid and px_rgba are stable throughout.
  - No dec_rtr is issued until the handshake.
  - Total output count stays 16.
- Timeout: decoder model never responds for pixIdx 7, TIMEOUT=64.
  - Pixel 7 is emitted 64 cycles after WAIT entry with rgba=0.
  - timeout_err=1 and stays 1.
  - Pixels 8..15 decode normally.
- Back-to-back blocks with in_valid held high.
  - Second descriptor accepted only in IDLE.
  - dec_block does not change during the first block.
  - The second block's coordinates appear on its 16 pixels.
- Spurious dec_color_rts pulses in ISSUE/OUT/IDLE are ignored: no extra pixels and no data corruption.
- rsrt asserted while in WAIT at idx 9.
  - All outputs go to reset values asynchronously.
  - After release: in_ready=1, and a new block starts at pixIdx 0.

Source files
------------

// File: rtl/etc_block_scheduler.sv
// etc_block_scheduler: walks one ETC 4x4 block through a single-pixel decoder and
// streams the 16 decoded pixels out in column-major order with image coordinates.
//
// state | meaning
// IDLE  | ready to accept a block descriptor
// ISSUE | one-cycle decode request for pixel idx
// WAIT  | waiting for decoder result strobe or timeout
// OUT   | pixel presented downstream until accepted
module etc_block_scheduler #(
   parameter int COORD_W = 12,
   parameter int TIMEOUT = 64
) (
   input  logic               sclk,
   input  logic               rsrt,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [63:0]        in_block,
   input  logic [2:0]         in_mode,
   input  logic               in_punch,
   input  logic               in_alpha,
   input  logic [COORD_W-1:0] in_blk_x,
   input  logic [COORD_W-1:0] in_blk_y,
   output logic               dec_rtr,
   output logic [2:0]         dec_mode,
   output logic [63:0]        dec_block,
   output logic               dec_punch,
   output logic               dec_alpha,
   output logic [3:0]         dec_pixIdx,
   input  logic               dec_color_rts,
   input  logic [7:0]         dec_r,
   input  logic [7:0]         dec_g,
   input  logic [7:0]         dec_b,
   input  logic [7:0]         dec_a,
   output logic               px_valid,
   input  logic               px_ready,
   output logic [COORD_W+1:0] px_x,
   output logic [COORD_W+1:0] px_y,
   output logic [31:0]        px_rgba,
   output logic               px_last,
   output logic               timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         idx;
   logic [CNT_W-1:0]   wait_cnt;
   logic [COORD_W-1:0] blk_x;
   logic [COORD_W-1:0] blk_y;
   logic               accept;
   logic               rts_hit;
   logic               wait_tc;
   logic               px_fire;

   assign accept  = (state == IDLE) && in_valid;
   assign rts_hit = (state == WAIT) && dec_color_rts;
   // a result strobe on the terminal cycle beats the timeout
   assign wait_tc = (state == WAIT) && !dec_color_rts && (wait_cnt == '0);
   assign px_fire = (state == OUT) && px_ready;

   always_ff @(posedge sclk or negedge rsrt) begin
      if (!rsrt) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (rts_hit || wait_tc) state_nxt = OUT;
         end
         OUT: begin
            if (px_ready) state_nxt = (idx == 4'd15) ? IDLE : ISSUE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      dec_rtr  = 1'b0;
      px_valid = 1'b0;
      px_last  = 1'b0;
      case (state)
         IDLE:  in_ready = 1'b1;
         ISSUE: dec_rtr  = 1'b1;
         OUT: begin
            px_valid = 1'b1;
            px_last  = (idx == 4'd15);
         end
         default: ;
      endcase
   end

   always_ff @(posedge sclk or negedge rsrt) begin
      if (!rsrt) begin
         dec_block   <= '0;
         dec_mode    <= '0;
         dec_punch   <= 1'b0;
         dec_alpha   <= 1'b0;
         blk_x       <= '0;
         blk_y       <= '0;
         idx         <= '0;
         wait_cnt    <= '0;
         px_rgba     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (accept) begin
            dec_block <= in_block;
            dec_mode  <= in_mode;
            dec_punch <= in_punch;
            dec_alpha <= in_alpha;
            blk_x     <= in_blk_x;
            blk_y     <= in_blk_y;
            idx       <= '0;
         end else if (px_fire && (idx != 4'd15)) begin
            idx <= idx + 4'd1;
         end

         // down-counter: loaded on request, terminal count at zero
         if (state == ISSUE) begin
            wait_cnt <= CNT_LOAD;
         end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end

         if (rts_hit) begin
            px_rgba <= {dec_r, dec_g, dec_b, dec_a};
         end else if (wait_tc) begin
            px_rgba     <= '0;
            timeout_err <= 1'b1;
         end
      end
   end

   assign dec_pixIdx = idx;

   // column-major within the block: idx[3:2] is the column, idx[1:0] the row
   assign px_x = {blk_x, 2'b00} + {{COORD_W{1'b0}}, idx[3:2]};
   assign px_y = {blk_y, 2'b00} + {{COORD_W{1'b0}}, idx[1:0]};

endmodule

// File: tb/tb_etc_block_scheduler.sv
// Scoreboard bench for etc_block_scheduler: a behavioural decoder answers requests,
// expected requests and pixels are queued at descriptor acceptance and checked by monitors.
module tb_etc_block_scheduler;
   localparam int COORD_W = 12;
   localparam int TIMEOUT = 64;
   localparam int XW      = COORD_W + 2;

   logic               sclk = 1'b0;
   logic               rsrt;
   logic               in_valid;
   logic               in_ready;
   logic [63:0]        in_block;
   logic [2:0]         in_mode;
   logic               in_punch;
   logic               in_alpha;
   logic [COORD_W-1:0] in_blk_x;
   logic [COORD_W-1:0] in_blk_y;
   logic               dec_rtr;
   logic [2:0]         dec_mode;
   logic [63:0]        dec_block;
   logic               dec_punch;
   logic               dec_alpha;
   logic [3:0]         dec_pixIdx;
   logic               dec_color_rts;
   logic [7:0]         dec_r, dec_g, dec_b, dec_a;
   logic               px_valid;
   logic               px_ready;
   logic [XW-1:0]      px_x, px_y;
   logic [31:0]        px_rgba;
   logic               px_last;
   logic               timeout_err;

   etc_block_scheduler #(.COORD_W(COORD_W), .TIMEOUT(TIMEOUT)) dut (
      .sclk(sclk), .rsrt(rsrt),
      .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_mode(in_mode),
      .in_punch(in_punch), .in_alpha(in_alpha), .in_blk_x(in_blk_x), .in_blk_y(in_blk_y),
      .dec_rtr(dec_rtr), .dec_mode(dec_mode), .dec_block(dec_block), .dec_punch(dec_punch),
      .dec_alpha(dec_alpha), .dec_pixIdx(dec_pixIdx), .dec_color_rts(dec_color_rts),
      .dec_r(dec_r), .dec_g(dec_g), .dec_b(dec_b), .dec_a(dec_a),
      .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
      .px_rgba(px_rgba), .px_last(px_last), .timeout_err(timeout_err)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic [63:0] blk;
      logic [2:0]  mode;
      logic        p;
      logic        a;
      logic [3:0]  idx;
      logic        drop;
   } req_t;

   typedef struct {
      logic [XW-1:0] x;
      logic [XW-1:0] y;
      logic [31:0]   rgba;
      logic          last;
      logic          tmo;
      logic          stall;
   } px_t;

   req_t        exp_req[$];
   px_t         exp_px[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc = 0;
   int unsigned last_rtr_cyc = 0;
   int          rtr_count = 0;
   bit          drop_seen = 1'b0;
   bit          exp_terr = 1'b0;
   bit          spur_en = 1'b0;
   bit          bp_rand = 1'b0;
   int          lat_min = 2;
   int          lat_max = 2;

   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // colour the behavioural decoder returns for a given block and pixel
   function automatic logic [31:0] col(input logic [63:0] b, input logic [3:0] i);
      logic [127:0] d;
      d = {b, b} >> (4 * int'(i));
      return d[31:0] ^ {8{i}};
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_px_valid"}, 64'(px_valid), 64'd0);
      check({tag, "_dec_rtr"}, 64'(dec_rtr), 64'd0);
      check({tag, "_pixidx"}, 64'(dec_pixIdx), 64'd0);
      check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
      check({tag, "_rgba"}, 64'(px_rgba), 64'd0);
      check({tag, "_dec_block"}, dec_block, 64'd0);
      check({tag, "_misc"}, 64'({dec_mode, dec_punch, dec_alpha, px_last, px_x, px_y}), 64'd0);
   endtask

   // called at a negedge; returns one negedge after the descriptor is accepted
   task automatic send(input int bx, input int by, input int mode, input int drop,
                       input bit stall, input bit hold);
      logic [63:0] blk;
      logic [2:0]  md;
      logic        pu, al;
      int          n;
      req_t        r;
      px_t         p;
      blk = {$urandom, $urandom};
      md  = (mode < 0) ? 3'($urandom_range(0, 4)) : 3'(mode);
      pu  = 1'($urandom);
      al  = 1'($urandom);
      in_block = blk; in_mode = md; in_punch = pu; in_alpha = al;
      in_blk_x = COORD_W'(bx); in_blk_y = COORD_W'(by); in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 3000) begin
         @(negedge sclk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      for (int i = 0; i < 16; i++) begin
         r.blk = blk; r.mode = md; r.p = pu; r.a = al; r.idx = 4'(i); r.drop = (i == drop);
         exp_req.push_back(r);
         p.x     = XW'(bx * 4 + i / 4);
         p.y     = XW'(by * 4 + i % 4);
         p.rgba  = (i == drop) ? 32'd0 : col(blk, 4'(i));
         p.last  = (i == 15);
         p.tmo   = (i == drop);
         p.stall = stall && (i == 4);
         exp_px.push_back(p);
      end
      @(negedge sclk);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_px.size() != 0 || exp_req.size() != 0) && n < budget) begin
         @(negedge sclk);
         n++;
      end
      check("drain_pixels_left", 64'(exp_px.size()), 64'd0);
      repeat (2) @(negedge sclk);
   endtask

   // behavioural decoder: answers each request after a random latency, can drop one,
   // and throws garbage strobes whenever no request is outstanding
   initial begin : decoder
      req_t r;
      int   dly;
      bit   outst;
      dec_color_rts = 1'b0;
      {dec_r, dec_g, dec_b, dec_a} = 32'd0;
      dly = 0;
      outst = 1'b0;
      forever begin
         @(negedge sclk);
         dec_color_rts = 1'b0;
         if (!rsrt) begin
            outst = 1'b0;
            dly = 0;
            continue;
         end
         if (dec_rtr) begin
            rtr_count++;
            last_rtr_cyc = cyc;
            if (exp_req.size() == 0) begin
               check("extra_request", 64'(dec_rtr), 64'd0);
               dly = 1;
            end else begin
               r = exp_req.pop_front();
               check("req_pixidx", 64'(dec_pixIdx), 64'(r.idx));
               check("req_block", dec_block, r.blk);
               check("req_mode_flags", 64'({dec_mode, dec_punch, dec_alpha}), 64'({r.mode, r.p, r.a}));
               if (r.drop) drop_seen = 1'b1;
               dly = r.drop ? -1 : int'($urandom_range(lat_max, lat_min));
            end
            outst = 1'b1;
            if (spur_en && $urandom_range(0, 3) == 0) begin
               dec_color_rts = 1'b1;
               {dec_r, dec_g, dec_b, dec_a} = $urandom;
            end
         end else if (outst) begin
            if (dly > 0) begin
               dly--;
               if (dly == 0) begin
                  dec_color_rts = 1'b1;
                  {dec_r, dec_g, dec_b, dec_a} = col(dec_block, dec_pixIdx);
                  outst = 1'b0;
               end
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            dec_color_rts = 1'b1;
            {dec_r, dec_g, dec_b, dec_a} = $urandom;
         end
      end
   end

   // output monitor: drives px_ready and checks every pixel handshake against the queue
   initial begin : monitor
      px_t           e;
      logic [XW-1:0] hx, hy;
      logic [31:0]   hr;
      logic          hl;
      bit            held;
      bit            chk_rdy;
      int            stall_cnt;
      px_ready = 1'b0;
      held = 1'b0;
      chk_rdy = 1'b0;
      stall_cnt = 0;
      hx = '0; hy = '0; hr = '0; hl = 1'b0;
      forever begin
         @(negedge sclk);
         if (!rsrt) begin
            held = 1'b0; chk_rdy = 1'b0; stall_cnt = 0; px_ready = 1'b0;
            continue;
         end
         if (chk_rdy) begin
            check("in_ready_after_last", 64'(in_ready), 64'd1);
            chk_rdy = 1'b0;
         end
         if (px_valid && dec_rtr) check("rtr_while_px_valid", 64'(dec_rtr), 64'd0);
         if (px_valid) begin
            if (held) begin
               check("hold_xy", 64'({px_x, px_y}), 64'({hx, hy}));
               check("hold_rgba_last", 64'({px_rgba, px_last}), 64'({hr, hl}));
            end else if (exp_px.size() != 0 && exp_px[0].tmo) begin
               check("timeout_latency", 64'(cyc - last_rtr_cyc), 64'(TIMEOUT + 1));
               exp_terr = 1'b1;
            end
            if (exp_px.size() == 0) begin
               check("extra_pixel", 64'(px_valid), 64'd0);
               px_ready = 1'b1;
               held = 1'b0;
            end else begin
               e = exp_px[0];
               if (e.stall && stall_cnt < 10) begin
                  px_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  px_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
               end
               if (px_ready) begin
                  void'(exp_px.pop_front());
                  check("px_x", 64'(px_x), 64'(e.x));
                  check("px_y", 64'(px_y), 64'(e.y));
                  check("px_rgba", 64'(px_rgba), 64'(e.rgba));
                  check("px_last", 64'(px_last), 64'(e.last));
                  check("timeout_err", 64'(timeout_err), 64'(exp_terr));
                  if (e.last) chk_rdy = 1'b1;
                  held = 1'b0;
                  stall_cnt = 0;
               end else begin
                  held = 1'b1;
                  hx = px_x; hy = px_y; hr = px_rgba; hl = px_last;
               end
            end
         end else begin
            if (held) check("px_valid_dropped", 64'(px_valid), 64'd1);
            held = 1'b0;
            px_ready = bp_rand ? 1'($urandom) : 1'b1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      rsrt = 1'b0;
      in_valid = 1'b0; in_block = '0; in_mode = '0; in_punch = 1'b0; in_alpha = 1'b0;
      in_blk_x = '0; in_blk_y = '0;
      repeat (3) @(negedge sclk);
      check_reset("por");
      #2 rsrt = 1'b1;
      @(negedge sclk);

      // single block, Individual mode, fixed latency, no backpressure
      lat_min = 2; lat_max = 2; bp_rand = 1'b0; spur_en = 1'b0; rtr_count = 0;
      send(3, 5, 0, -1, 1'b0, 1'b0);
      drain(2000);
      check("blockA_rtr_count", 64'(rtr_count), 64'd16);

      // 10-cycle stall on pixel 4
      lat_min = 1; lat_max = 3; rtr_count = 0;
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1, -1, 1'b1, 1'b0);
      drain(2000);
      check("blockB_rtr_count", 64'(rtr_count), 64'd16);

      // decoder never answers pixel 7
      lat_min = 2; lat_max = 2;
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1, 7, 1'b0, 1'b0);
      drain(3000);
      check("timeout_err_set", 64'(timeout_err), 64'd1);

      // back-to-back blocks, in_valid held, random latency, backpressure and spurious strobes
      lat_min = 1; lat_max = 5; bp_rand = 1'b1; spur_en = 1'b1; rtr_count = 0;
      for (int b = 0; b < 4; b++) begin
         send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1,
              (b == 1) ? int'($urandom_range(0, 15)) : -1, 1'b0, b < 3);
      end
      drain(8000);
      check("b2b_rtr_count", 64'(rtr_count), 64'd64);
      check("timeout_err_sticky", 64'(timeout_err), 64'd1);

      // reset while waiting on pixel 9
      bp_rand = 1'b0; drop_seen = 1'b0;
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1, 9, 1'b0, 1'b0);
      for (int n = 0; n < 2000 && !drop_seen; n++) @(negedge sclk);
      check("reached_pixel9", 64'(drop_seen), 64'd1);
      repeat (5) @(negedge sclk);
      #2 rsrt = 1'b0;
      #1 check_reset("mid_block");
      exp_px.delete();
      exp_req.delete();
      exp_terr = 1'b0;
      repeat (3) @(negedge sclk);
      #2 rsrt = 1'b1;
      @(negedge sclk);
      check("post_reset_in_ready", 64'(in_ready), 64'd1);
      rtr_count = 0;
      send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1, -1, 1'b0, 1'b0);
      drain(3000);
      check("post_reset_rtr_count", 64'(rtr_count), 64'd16);
      check("post_reset_timeout_err", 64'(timeout_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
